// File: rtl/demux_stream_pkg.sv
// Shared types and constants for the demux_stream block.
package demux_stream_pkg;

  // Output stage occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Per-channel transfer counter width and saturation value
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage : demux_stream_pkg

// File: rtl/demux_stream_dec.sv
// Channel select decoder: one-hot channel enable plus out-of-range flag.
module demux_stream_dec #(
  parameter  int unsigned NCH = 4,
  localparam int unsigned SW  = $clog2(NCH)
) (
  input  logic [SW-1:0]  sel,
  input  logic           en,
  output logic [NCH-1:0] onehot,
  output logic           oor
);

  logic [NCH-1:0] match;

  // Decode sel; anything that matches no channel is out of range
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      match[i] = (sel == SW'(i));
    end
    onehot = en ? match : '0;
    oor    = en & ~(|match);
  end

endmodule : demux_stream_dec

// File: rtl/demux_stream.sv
// Registered 1-to-NCH stream demultiplexer with valid/ready on every side.
// Optional per-channel saturating transfer counters: define DEMUX_STREAM_CNT_EN.
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter  int unsigned DW  = 8,
  parameter  int unsigned NCH = 4,
  localparam int unsigned SW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic [SW-1:0]        in_sel,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [DW-1:0]        out_data,
  output logic                 err_sel
`ifdef DEMUX_STREAM_CNT_EN
  ,
  output logic [NCH*CNT_W-1:0] cnt_flat,
  input  logic                 clr_cnt
`endif
);

  state_e         state;
  logic [SW-1:0]  hold_sel;
  logic [NCH-1:0] sel_onehot;
  logic           sel_oor;
  logic           hs;
  logic           load;
  logic           drain;

  demux_stream_dec #(
    .NCH (NCH)
  ) u_dec (
    .sel    (in_sel),
    .en     (in_valid),
    .onehot (sel_onehot),
    .oor    (sel_oor)
  );

  // Handshake qualifiers; in_ready depends only on state and out_ready
  always_comb begin
    in_ready = (state == ST_EMPTY) | out_ready[hold_sel];
    drain    = (state == ST_FULL) & out_ready[hold_sel];
    hs       = in_valid & in_ready;
    load     = hs & ~sel_oor;
  end

  // Output stage FSM with registered valid/data/error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      hold_sel  <= '0;
      out_data  <= '0;
      out_valid <= '0;
      err_sel   <= 1'b0;
    end else begin
      err_sel <= hs & sel_oor;
      case (state)
        ST_EMPTY: begin
          if (load) begin
            state     <= ST_FULL;
            hold_sel  <= in_sel;
            out_data  <= in_data;
            out_valid <= sel_onehot;
          end
        end
        ST_FULL: begin
          if (load) begin
            hold_sel  <= in_sel;
            out_data  <= in_data;
            out_valid <= sel_onehot;
          end else if (drain) begin
            state     <= ST_EMPTY;
            out_valid <= '0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= '0;
        end
      endcase
    end
  end

`ifdef DEMUX_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_q [NCH];

  // Saturating per-channel transfer counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (clr_cnt) begin
          cnt_q[i] <= '0;
        end else if (out_valid[i] && out_ready[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Flatten counters onto the output port
  always_comb begin
    cnt_flat = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule : demux_stream
